// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single-precision multiplier.
//
// The significand product is built by a radix-2 shift-add, one multiplier
// bit per clock over 24 cycles. A start/busy/done handshake issues one
// operation at a time. Operands whose exponent field is all ones raise
// Exception. Operands whose exponent field is zero are treated as zero.
// Rounding is truncation. Denormal results are flushed to zero.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only when idle
//   A, B      in   operands {sign, exp, frac}
//   busy      out  an operation is in flight
//   done      out  one-cycle pulse; result and flags are valid from here on
//   result    out  product
//   Exception out  an operand had an all-ones exponent field
//   overflow  out  finite product exponent too large
//   underflow out  product exponent too small; result flushed to zero
module fp_mul_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [EXP_W+MANT_W:0]     A,
    input  logic [EXP_W+MANT_W:0]     B,
    output logic                      busy,
    output logic                      done,
    output logic [EXP_W+MANT_W:0]     result,
    output logic                      Exception,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int WORD_W = EXP_W + MANT_W + 1;
    localparam int SIG_W  = MANT_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int ESUM_W = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W);

    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(SIG_W - 1);
    localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
    localparam logic signed [ESUM_W-1:0] BIAS_S    = ESUM_W'(BIAS);
    localparam logic signed [ESUM_W-1:0] EXP_ALL_S = ESUM_W'((1 << EXP_W) - 1);
    localparam logic signed [ESUM_W-1:0] ONE_S     = ESUM_W'(1);
    localparam logic signed [ESUM_W-1:0] ZERO_S    = '0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        NORM
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PROD_W-1:0]          acc_q, acc_d;
    logic [SIG_W-1:0]           ma_q, ma_d;
    logic [SIG_W-1:0]           mb_q, mb_d;
    logic                       sign_q, sign_d;
    logic signed [ESUM_W-1:0]   esum_q, esum_d;

    // Completed results pass through a one-cycle staging register before
    // reaching the outputs, so done lands one edge after the core returns
    // to IDLE. While it is pending the core does not accept new work.
    logic                       pend_q, pend_d;
    logic [WORD_W-1:0]          pend_res_q, pend_res_d;
    logic                       pend_exc_q, pend_exc_d;
    logic                       pend_ovf_q, pend_ovf_d;
    logic                       pend_unf_q, pend_unf_d;

    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [WORD_W-1:0]          result_q, result_d;
    logic                       exc_q, exc_d;
    logic                       ovf_q, ovf_d;
    logic                       unf_q, unf_d;

    logic [EXP_W-1:0]           a_exp, b_exp;
    logic                       a_inf, b_inf, a_zero, b_zero;
    logic                       sign_in;
    logic                       accept;
    logic [MANT_W-1:0]          norm_frac;
    logic signed [ESUM_W-1:0]   norm_exp;

    assign a_exp   = A[WORD_W-2:MANT_W];
    assign b_exp   = B[WORD_W-2:MANT_W];
    assign a_inf   = (a_exp == {EXP_W{1'b1}});
    assign b_inf   = (b_exp == {EXP_W{1'b1}});
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign sign_in = A[WORD_W-1] ^ B[WORD_W-1];
    assign accept  = (state_q == IDLE) && start && !pend_q;

    // Normalisation: the product of two [1,2) significands lies in [1,4),
    // so at most one extra exponent increment is needed.
    always_comb begin
        norm_frac = acc_q[PROD_W-3 -: MANT_W];
        norm_exp  = esum_q;
        if (acc_q[PROD_W-1]) begin
            norm_frac = acc_q[PROD_W-2 -: MANT_W];
            norm_exp  = esum_q + ONE_S;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        sign_d     = sign_q;
        esum_d     = esum_q;
        pend_d     = 1'b0;
        pend_res_d = pend_res_q;
        pend_exc_d = pend_exc_q;
        pend_ovf_d = pend_ovf_q;
        pend_unf_d = pend_unf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d     = sign_in;
                    esum_d     = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
                    ma_d       = {1'b1, A[MANT_W-1:0]};
                    mb_d       = {1'b1, B[MANT_W-1:0]};
                    cnt_d      = '0;
                    acc_d      = '0;
                    pend_exc_d = 1'b0;
                    pend_ovf_d = 1'b0;
                    pend_unf_d = 1'b0;
                    // Inf/NaN beats zero, so Inf x 0 reports Exception.
                    if (a_inf || b_inf) begin
                        pend_d     = 1'b1;
                        pend_exc_d = 1'b1;
                        pend_res_d = {sign_in, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    end else if (a_zero || b_zero) begin
                        pend_d     = 1'b1;
                        pend_res_d = {sign_in, {(WORD_W-1){1'b0}}};
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (mb_q[cnt_q]) begin
                    acc_d = acc_q + ({{SIG_W{1'b0}}, ma_q} << cnt_q);
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                pend_d  = 1'b1;
                state_d = IDLE;
                if (norm_exp >= EXP_ALL_S) begin
                    pend_ovf_d = 1'b1;
                    pend_res_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                end else if (norm_exp <= ZERO_S) begin
                    pend_unf_d = 1'b1;
                    pend_res_d = {sign_q, {(WORD_W-1){1'b0}}};
                end else begin
                    pend_res_d = {sign_q, norm_exp[EXP_W-1:0], norm_frac};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage. Flags drop at each accept; result holds until the next
    // completion overwrites it.
    always_comb begin
        busy_d   = (state_q != IDLE);
        done_d   = pend_q;
        result_d = result_q;
        exc_d    = exc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (pend_q) begin
            result_d = pend_res_q;
            exc_d    = pend_exc_q;
            ovf_d    = pend_ovf_q;
            unf_d    = pend_unf_q;
        end else if (accept) begin
            exc_d = 1'b0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            sign_q     <= 1'b0;
            esum_q     <= '0;
            pend_q     <= 1'b0;
            pend_res_q <= '0;
            pend_exc_q <= 1'b0;
            pend_ovf_q <= 1'b0;
            pend_unf_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            exc_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            sign_q     <= sign_d;
            esum_q     <= esum_d;
            pend_q     <= pend_d;
            pend_res_q <= pend_res_d;
            pend_exc_q <= pend_exc_d;
            pend_ovf_q <= pend_ovf_d;
            pend_unf_q <= pend_unf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign Exception = exc_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed-vector scoreboard bench for fp_mul_seq.
// Stimulus pushes the hand-computed response (value, flags, done cycle)
// into a queue; a monitor pops and compares whenever done pulses.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Exception;
    logic        overflow;
    logic        underflow;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        ovf;
        logic        unf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_compared;
    int   n_mismatched;

    fp_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .Exception (Exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges; at a falling edge it equals the number of the
    // most recent rising edge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_done: got done=1 result=%h, expected no done (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result",    result,          e.res);
                checkOutput("Exception", {31'b0, Exception}, {31'b0, e.exc});
                checkOutput("overflow",  {31'b0, overflow},  {31'b0, e.ovf});
                checkOutput("underflow", {31'b0, underflow}, {31'b0, e.unf});
                checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic waitDrain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL timeout: got no done within bound, expected %0d result(s)", sb.size());
            sb.delete();
        end
    endtask

    task automatic pushExpect(input logic [31:0] res, input logic exc, input logic ovf,
                              input logic unf, input int done_cyc);
        exp_t e;
        e.res = res;
        e.exc = exc;
        e.ovf = ovf;
        e.unf = unf;
        e.cyc = done_cyc;
        sb.push_back(e);
    endtask

    // One operation: start is sampled at the next rising edge T, done is
    // expected at edge T+lat. A/B are scrambled after the accept edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                 input logic exc, input logic ovf, input logic unf, input int lat);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        pushExpect(res, exc, ovf, unf, cyc + 1 + lat);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        waitDrain();
    endtask

    initial begin
        int t_acc;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        A            = 32'h0;
        B            = 32'h0;
        repeat (3) @(negedge clk);

        checkOutput("reset_busy",   {31'b0, busy},      32'h0);
        checkOutput("reset_done",   {31'b0, done},      32'h0);
        checkOutput("reset_result", result,             32'h0);
        checkOutput("reset_exc",    {31'b0, Exception}, 32'h0);
        checkOutput("reset_ovf",    {31'b0, overflow},  32'h0);
        checkOutput("reset_unf",    {31'b0, underflow}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2.0 x 3.0 with busy tracking and an ignored start during CALC.
        A     = 32'h40000000;
        B     = 32'h40400000;
        start = 1'b1;
        t_acc = cyc + 1;
        pushExpect(32'h40C00000, 1'b0, 1'b0, 1'b0, t_acc + 26);
        @(negedge clk);
        start = 1'b0;
        A     = 32'h12345678;
        B     = 32'h9ABCDEF0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 4) begin
                A     = 32'h7F800000;
                B     = 32'h3F800000;
                start = 1'b1;
            end else if (k == 5) begin
                start = 1'b0;
            end
            if (k == 1 || k == 12 || k == 25)
                checkOutput($sformatf("busy_T+%0d", k), {31'b0, busy}, 32'h1);
            if (k == 26)
                checkOutput("busy_T+26", {31'b0, busy}, 32'h0);
        end
        waitDrain();
        repeat (3) @(negedge clk);

        applyStimulus(32'hBFC00000, 32'h40200000, 32'hC0700000, 1'b0, 1'b0, 1'b0, 26);
        applyStimulus(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 1'b0, 26);
        applyStimulus(32'h00000000, 32'h40B33333, 32'h00000000, 1'b0, 1'b0, 1'b0, 1);
        applyStimulus(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(32'h7F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1, 1'b0, 26);
        applyStimulus(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0, 1'b1, 26);
        applyStimulus(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0, 26);

        // Abort mid-operation: outputs clear at once and no done follows.
        @(negedge clk);
        A     = 32'h3FC00000;
        B     = 32'h3FC00000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy",   {31'b0, busy}, 32'h0);
        checkOutput("abort_done",   {31'b0, done}, 32'h0);
        checkOutput("abort_result", result,        32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        applyStimulus(32'hBFC00000, 32'h40200000, 32'hC0700000, 1'b0, 1'b0, 1'b0, 26);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion by 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
